ram_bist_ctrl: RTL and testbench

//  Upstream sequencer for the 1024x8 single-access RAM (cs/write/read/address/data_in/data_out).
//  On start it fills every location with a deterministic pattern, reads each one back, and

---
 rtl/ram_bist_pkg.sv | 18 +
 rtl/ram_bist_checker.sv | 56 +++++
 rtl/ram_bist_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM self-test controller: state encodings and the fill pattern.
package ram_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WR_SETUP  = 3'd1;
  localparam state_t S_WR_STROBE = 3'd2;
  localparam state_t S_RD_SETUP  = 3'd3;
  localparam state_t S_RD_CMP    = 3'd4;
  localparam state_t S_DONE      = 3'd5;

  // Callers truncate the result to the word width, giving (2*a) mod 2**WORD_SIZE.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a << 1;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Readback comparator: counts mismatching locations (saturating) and captures the first one.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [ADDR_SIZE:0]   fail_count_o,
  output logic [ADDR_SIZE-1:0] first_fail_addr_o,
  output logic                 zero_d_o
);

  logic [ADDR_SIZE:0]   fail_count_q, fail_count_d;
  logic [ADDR_SIZE-1:0] first_fail_q, first_fail_d;
  logic                 mismatch;

  assign mismatch = data_i != WORD_SIZE'(pat(32'(addr_i)));

  always_comb begin
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    if (clear_i) begin
      fail_count_d = '0;
      first_fail_d = '0;
    end else if (en_i && mismatch) begin
      if (!(&fail_count_q)) begin
        fail_count_d = fail_count_q + 1'b1;
      end
      if (fail_count_q == '0) begin
        first_fail_d = addr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign fail_count_o      = fail_count_q;
  assign first_fail_addr_o = first_fail_q;
  // Lets the top register pass on the same edge as the final comparison.
  assign zero_d_o          = fail_count_d == '0;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Memory self-test sequencer: writes pat(a) to every location, reads each back and compares.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic [ADDR_SIZE-1:0] address_o,
  output logic [WORD_SIZE-1:0] data_in_o,
  output logic                 cs_o,
  output logic                 write_o,
  output logic                 read_o,
  input  logic [WORD_SIZE-1:0] data_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ADDR_SIZE:0]   fail_count_o,
  output logic [ADDR_SIZE-1:0] first_fail_addr_o
);

  localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_SIZE - 1);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 last_addr, start_ok, zero_d;

  logic [ADDR_SIZE-1:0] address_q, address_d;
  logic [WORD_SIZE-1:0] data_in_q, data_in_d;
  logic                 cs_q, cs_d, write_q, write_d, read_q, read_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  assign last_addr = addr_q == LastAddr;
  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WR_SETUP;
          addr_d  = '0;
        end
      end
      S_WR_SETUP: state_d = S_WR_STROBE;
      S_WR_STROBE: begin
        if (last_addr) begin
          state_d = S_RD_SETUP;
          addr_d  = '0;
        end else begin
          state_d = S_WR_SETUP;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_RD_SETUP: state_d = S_RD_CMP;
      S_RD_CMP: begin
        if (last_addr) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else begin
          state_d = S_RD_SETUP;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every RAM-side pin comes straight from a flop.
  always_comb begin
    address_d = '0;
    data_in_d = '0;
    cs_d      = 1'b0;
    write_d   = 1'b0;
    read_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_WR_SETUP, S_WR_STROBE: begin
        address_d = addr_d;
        data_in_d = WORD_SIZE'(pat(32'(addr_d)));
        cs_d      = 1'b1;
        write_d   = state_d == S_WR_STROBE;
        busy_d    = 1'b1;
      end
      S_RD_SETUP, S_RD_CMP: begin
        address_d = addr_d;
        cs_d      = 1'b1;
        read_d    = 1'b1;
        busy_d    = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    pass_d = done_d && zero_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      address_q <= '0;
      data_in_q <= '0;
      cs_q      <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      address_q <= address_d;
      data_in_q <= data_in_d;
      cs_q      <= cs_d;
      write_q   <= write_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  ram_bist_checker #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) u_checker (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .clear_i          (start_ok),
    .en_i             (state_q == S_RD_CMP),
    .addr_i           (addr_q),
    .data_i           (data_out_i),
    .fail_count_o     (fail_count_o),
    .first_fail_addr_o(first_fail_addr_o),
    .zero_d_o         (zero_d)
  );

  assign address_o = address_q;
  assign data_in_o = data_in_q;
  assign cs_o      = cs_q;
  assign write_o   = write_q;
  assign read_o    = read_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench: two controllers (1024 and 16 locations) driving behavioural RAMs with stuck-bit faults.
module tb_ram_bist_ctrl;

  localparam int MA = 1024;
  localparam int MB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default geometry
  logic       rst_a, start_a, cs_a, wr_a, rd_a, busy_a, done_a, pass_a;
  logic [9:0] addr_a, ffa_a;
  logic [7:0] din_a, dout_a;
  logic [10:0] fc_a;
  logic [7:0] mem_a [MA];
  logic [7:0] fm_a [MA];
  logic [7:0] fv_a [MA];

  // Instance B: 16 locations
  logic       rst_b, start_b, cs_b, wr_b, rd_b, busy_b, done_b, pass_b;
  logic [3:0] addr_b, ffa_b;
  logic [7:0] din_b, dout_b;
  logic [4:0] fc_b;
  logic [7:0] mem_b [MB];
  logic [7:0] fm_b [MB];
  logic [7:0] fv_b [MB];

  ram_bist_ctrl u_dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .address_o(addr_a), .data_in_o(din_a),
    .cs_o(cs_a), .write_o(wr_a), .read_o(rd_a), .data_out_i(dout_a), .busy_o(busy_a),
    .done_o(done_a), .pass_o(pass_a), .fail_count_o(fc_a), .first_fail_addr_o(ffa_a)
  );

  ram_bist_ctrl #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEM_SIZE(MB)) u_dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start_b), .address_o(addr_b), .data_in_o(din_b),
    .cs_o(cs_b), .write_o(wr_b), .read_o(rd_b), .data_out_i(dout_b), .busy_o(busy_b),
    .done_o(done_b), .pass_o(pass_b), .fail_count_o(fc_b), .first_fail_addr_o(ffa_b)
  );

  // RAM models: write on a clock edge while cs&write, read returns stored word with faults applied
  always @(posedge clk) if (cs_a && wr_a) mem_a[addr_a] <= din_a;
  always @(posedge clk) if (cs_b && wr_b) mem_b[addr_b] <= din_b;
  always_comb begin
    dout_a = '0;
    if (cs_a && rd_a)
      dout_a = (mem_a[addr_a] & ~fm_a[addr_a]) | (fv_a[addr_a] & fm_a[addr_a]);
  end
  always_comb begin
    dout_b = '0;
    if (cs_b && rd_b)
      dout_b = (mem_b[addr_b] & ~fm_b[addr_b]) | (fv_b[addr_b] & fm_b[addr_b]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus protocol monitors: strobe only after a setup cycle with identical address/data
  logic [9:0] pa_a = '0;
  logic [7:0] pd_a = '0;
  logic       pcs_a = 1'b0, pwr_a = 1'b0;
  logic [3:0] pa_b = '0;
  logic [7:0] pd_b = '0;
  logic       pcs_b = 1'b0, pwr_b = 1'b0;

  always @(posedge clk) begin
    if (cs_a || wr_a || rd_a) begin
      chk("proto_a", {31'd0, !(wr_a && rd_a) && cs_a && (!wr_a || (pcs_a && !pwr_a &&
          addr_a == pa_a && din_a == pd_a && din_a == 8'(2 * addr_a)))}, 32'd1);
    end
    pa_a <= addr_a; pd_a <= din_a; pcs_a <= cs_a; pwr_a <= wr_a;
  end

  always @(posedge clk) begin
    if (cs_b || wr_b || rd_b) begin
      chk("proto_b", {31'd0, !(wr_b && rd_b) && cs_b && (!wr_b || (pcs_b && !pwr_b &&
          addr_b == pa_b && din_b == pd_b && din_b == 8'(2 * addr_b)))}, 32'd1);
    end
    pa_b <= addr_b; pd_b <= din_b; pcs_b <= cs_b; pwr_b <= wr_b;
  end

  task automatic clear_faults();
    for (int i = 0; i < MA; i++) begin fm_a[i] = '0; fv_a[i] = '0; end
    for (int i = 0; i < MB; i++) begin fm_b[i] = '0; fv_b[i] = '0; end
  endtask

  task automatic set_fault(input bit sel_b, input int loc, input int b, input bit v);
    if (sel_b) begin fm_b[loc][b] = 1'b1; fv_b[loc][b] = v; end
    else begin fm_a[loc][b] = 1'b1; fv_a[loc][b] = v; end
  endtask

  // Reference: count locations whose faulty readback differs from (2*a) mod 256
  task automatic model(input bit sel_b, output int cnt, output int first);
    int n, lim, p, m, v;
    n = sel_b ? MB : MA;
    lim = sel_b ? 31 : 2047;
    cnt = 0;
    first = 0;
    for (int a = 0; a < n; a++) begin
      p = (2 * a) % 256;
      if (sel_b) begin m = fm_b[a]; v = fv_b[a]; end
      else begin m = fm_a[a]; v = fv_a[a]; end
      if (((p & ~m) | (v & m)) != p) begin
        if (cnt == 0) first = a;
        if (cnt < lim) cnt++;
      end
    end
  endtask

  task automatic run_a(input string tag, input int pulse, input bit hold);
    int ec, ef;
    model(1'b0, ec, ef);
    start_a = 1'b1;
    tick();
    chk({tag, "_busy0"}, {31'd0, busy_a}, 32'd1);
    chk({tag, "_done0"}, {31'd0, done_a}, 32'd0);
    for (int e = 1; e <= 4 * MA - 1; e++) begin
      start_a = hold || (e == pulse);
      tick();
    end
    chk({tag, "_early"}, {31'd0, done_a}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, done_a}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass_a}, {31'd0, ec == 0});
    chk({tag, "_fc"}, {21'd0, fc_a}, ec);
    chk({tag, "_ffa"}, {22'd0, ffa_a}, ef);
  endtask

  task automatic run_b(input string tag);
    int ec, ef;
    model(1'b1, ec, ef);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int e = 1; e <= 4 * MB - 1; e++) tick();
    chk({tag, "_early"}, {31'd0, done_b}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, done_b}, 32'd1);
    chk({tag, "_pass"}, {31'd0, pass_b}, {31'd0, ec == 0});
    chk({tag, "_fc"}, {27'd0, fc_b}, ec);
    chk({tag, "_ffa"}, {28'd0, ffa_b}, ef);
  endtask

  initial begin
    int r;
    clear_faults();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    chk("rst_outs", {22'd0, cs_a, wr_a, rd_a, busy_a, done_a, pass_a, addr_a[3:0]}, 32'd0);
    chk("rst_fc", {21'd0, fc_a}, 32'd0);
    chk("rst_ffa", {22'd0, ffa_a}, 32'd0);

    // Clean memory
    run_a("t1", -1, 1'b0);
    start_a = 1'b0;
    chk("mem0", {24'd0, mem_a[0]}, 32'd0);
    chk("mem5", {24'd0, mem_a[5]}, 32'd10);
    chk("mem200", {24'd0, mem_a[200]}, 32'd144);
    r = $urandom_range(0, MA - 1);
    chk("mem_rand", {24'd0, mem_a[r]}, (2 * r) % 256);
    tick();
    chk("done_hold", {31'd0, done_a}, 32'd1);

    // Single stuck bit
    set_fault(1'b0, 5, 0, 1'b1);
    run_a("t2", -1, 1'b0);
    chk("t2_fc_const", {21'd0, fc_a}, 32'd1);
    chk("t2_ffa_const", {22'd0, ffa_a}, 32'd5);

    // Three stuck bits, including the last location
    set_fault(1'b0, 7, 0, 1'b1);
    set_fault(1'b0, 300, 0, 1'b1);
    set_fault(1'b0, 1023, 0, 1'b1);
    fm_a[5] = '0;
    run_a("t3", -1, 1'b0);
    chk("t3_fc_const", {21'd0, fc_a}, 32'd3);
    chk("t3_ffa_const", {22'd0, ffa_a}, 32'd7);

    // Start pulse mid-test is ignored
    clear_faults();
    run_a("t4", 100, 1'b0);

    // Reset mid write phase aborts, then a fresh run passes
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e < 1500; e++) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("t5_abort", {26'd0, busy_a, cs_a, wr_a, rd_a, done_a, pass_a}, 32'd0);
    run_a("t5", -1, 1'b0);

    // Randomised stuck-bit faults
    for (int it = 0; it < 2; it++) begin
      clear_faults();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        set_fault(1'b0, $urandom_range(0, MA - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      run_a("rnd_a", -1, 1'b0);
    end

    // Start held high: reruns after a single DONE cycle
    clear_faults();
    run_a("t7", -1, 1'b1);
    tick();
    chk("t7_rerun", {30'd0, busy_a, done_a}, 32'd2);
    start_a = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;

    // Small geometry
    run_b("t6");
    chk("t6_mem15", {24'd0, mem_b[15]}, 32'd30);
    for (int it = 0; it < 3; it++) begin
      clear_faults();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++)
        set_fault(1'b1, $urandom_range(0, MB - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      run_b("rnd_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
